exp_mix_pipe: RTL and testbench
===============================

EXP_MIX_PIPE -- requirements
Module: exp_mix_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 1, giving the number of 32-bit half-blocks processed per beat (legal 1..4).
REQ-002 The block SHALL have parameter KEY_DEPTH, default 16, giving the number of stored 48-bit round keys (legal 2..16, power of two); KW = $clog2(KEY_DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_we  input  1  round-key write strobe.
REQ-006 key_waddr  input  KW  round-key write index.
REQ-007 key_wdata  input  48  round-key write value.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  block can accept an input beat.
REQ-010 in_data  input  32*LANES  right half-blocks; lane n at [32n+31:32n].
REQ-011 in_first  input  1  beat starts a new round sequence.
REQ-012 in_mode  input  1  0 = ascending key order (encrypt), 1 = descending (decrypt); sampled only on accepted in_first beats.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream accepts output beat.
REQ-015 out_data  output  48*LANES  expanded and key-mixed result; lane n at [48n+47:48n].
REQ-016 out_round  output  KW  key index used for the presented beat.
REQ-017 out_last  output  1  presented beat used the final key of the sequence.

Function
REQ-018 Expansion SHALL map each lane d[31:0] to e[47:0] where, for group g = 0..7, e[47-6g:42-6g] = {d[(32-4g) mod 32], d[31-4g], d[30-4g], d[29-4g], d[28-4g], d[(27-4g) mod 32]}.
REQ-019 Each lane result SHALL be e XOR key[idx], one shared key for all lanes of a beat.
REQ-020 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (single output register, no combinational in_valid->out_valid path).
REQ-021 Latency SHALL be exactly 1 cycle: an accepted beat appears on out_* the following cycle; full throughput of one beat per cycle under continuous out_ready.
REQ-022 out_valid SHALL stay high and out_data/out_round/out_last SHALL hold stable until out_valid && out_ready.
REQ-023 Key index idx: on an accepted in_first beat, idx = 0 if in_mode=0, KEY_DEPTH-1 if in_mode=1, and the mode register takes in_mode; otherwise idx = internal round counter.
REQ-024 After each accepted beat the counter SHALL become idx+1 (mode 0) or idx-1 (mode 1), modulo KEY_DEPTH (wraps; no stall at sequence end).
REQ-025 out_last SHALL be 1 iff idx = KEY_DEPTH-1 (mode 0) or idx = 0 (mode 1).
REQ-026 Counter and mode register SHALL not change on cycles with no accepted beat.
REQ-027 Key writes SHALL take effect on the next cycle; a beat accepted in the same cycle as a write to its idx SHALL use the old key value.
REQ-028 Key writes SHALL be accepted every cycle regardless of handshake state.

Reset
REQ-029 On reset: out_valid=0, out_data=0, out_round=0, out_last=0, counter=0, mode register=0, all key entries=0.
REQ-030 Reset SHALL dominate: any beat presented or key written in a reset cycle SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 LANES=1, keys all 0, in_data=32'h0000_0001, in_first=1, in_mode=0 -> next cycle out_data=48'h8000_0000_0002, out_round=0, out_last=0.
REQ-033 key[k]=48'h1 << k; 16 back-to-back beats of in_data=0, in_first on beat 0, mode 0, out_ready=1 -> out_data=key[0..15] in order, out_round 0..15, out_last only on round 15, one beat per cycle.
REQ-034 Same sequence with in_mode=1 -> out_round 15 down to 0, out_last only on round 0; a 17th beat without in_first wraps to round 15.
REQ-035 out_ready held 0 for 3 cycles with a pending beat -> in_ready=0, out_* stable, counter unchanged; on release the next beat uses the following round index.
REQ-036 key_we to index 0 with 48'hFFFF_FFFF_FFFF in the cycle a first beat (data 0) is accepted -> output equals old key[0]; next first beat outputs 48'hFFFF_FFFF_FFFF.
REQ-037 reset asserted while out_valid=1 mid-sequence -> next cycle out_valid=0, out_data=0; subsequent beat without in_first uses round 0 with key 0.

Source files
------------

// File: rtl/exp_mix_pipe.sv
// Purpose: expands each 32-bit lane to 48 bits with the E-bit pattern and XORs in a sequenced round key.
// Latency: one cycle from an accepted input beat to out_*; one beat per cycle sustained.
// Backpressure: a single output register; in_ready = !out_valid || out_ready, and out_* hold until taken.
//
// Ports:
//   clk, reset              sole clock; synchronous active-high reset
//   key_we/key_waddr/key_wdata   round-key table write port (takes effect next cycle)
//   in_valid/in_ready/in_data    input beat, LANES x 32-bit right half-blocks
//   in_first/in_mode        start a new sequence; 0 = ascending keys, 1 = descending
//   out_valid/out_ready/out_data output beat, LANES x 48-bit mixed results
//   out_round/out_last      key index used, and whether it ended the sequence
module exp_mix_pipe #(
    parameter  int LANES     = 1,
    parameter  int KEY_DEPTH = 16,
    localparam int KW        = $clog2(KEY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_we,
    input  logic [KW-1:0]         key_waddr,
    input  logic [47:0]           key_wdata,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_data,
    input  logic                  in_first,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [48*LANES-1:0]   out_data,
    output logic [KW-1:0]         out_round,
    output logic                  out_last
);

    localparam logic [KW-1:0] LAST_IDX = KW'(KEY_DEPTH - 1);

    logic [47:0]          key_q [KEY_DEPTH];
    logic [47:0]          key_d [KEY_DEPTH];
    logic [KW-1:0]        cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 out_valid_q, out_valid_d;
    logic [48*LANES-1:0]  out_data_q, out_data_d;
    logic [KW-1:0]        out_round_q, out_round_d;
    logic                 out_last_q, out_last_d;

    logic                 accept;
    logic                 sel_mode;
    logic [KW-1:0]        idx;
    logic                 last_hit;

    // Group g takes bits 31-4g..28-4g plus one neighbour on each side,
    // wrapping around the 32-bit word at both ends.
    function automatic logic [47:0] expand(input logic [31:0] d);
        logic [47:0] e;
        e = '0;
        for (int g = 0; g < 8; g++) begin
            e[47-6*g -: 6] = {d[(32-4*g) % 32], d[31-4*g], d[30-4*g],
                              d[29-4*g], d[28-4*g], d[(59-4*g) % 32]};
        end
        return e;
    endfunction

    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        accept   = in_valid && in_ready;
        // A first beat overrides both the direction and the starting index.
        sel_mode = in_first ? in_mode : mode_q;
        if (in_first) begin
            idx = in_mode ? LAST_IDX : '0;
        end else begin
            idx = cnt_q;
        end
        last_hit = sel_mode ? (idx == '0) : (idx == LAST_IDX);

        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        for (int k = 0; k < KEY_DEPTH; k++) begin
            key_d[k] = key_q[k];
        end

        // Writes land in key_d only, so a beat mixing this cycle sees the old key.
        if (key_we) begin
            key_d[key_waddr] = key_wdata;
        end

        if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                out_data_d[48*l +: 48] = expand(in_data[32*l +: 32]) ^ key_q[idx];
            end
            out_valid_d = 1'b1;
            out_round_d = idx;
            out_last_d  = last_hit;
            mode_d      = sel_mode;
            // Power-of-two depth: natural KW-bit wrap gives the modulo.
            cnt_d       = sel_mode ? (idx - KW'(1)) : (idx + KW'(1));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            for (int k = 0; k < KEY_DEPTH; k++) begin
                key_q[k] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            for (int k = 0; k < KEY_DEPTH; k++) begin
                key_q[k] <= key_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_exp_mix_pipe.sv
module tb_exp_mix_pipe;

    localparam int LANES = 2;
    localparam int KD    = 16;
    localparam int KW    = 4;

    logic                clk;
    logic                reset;
    logic                key_we;
    logic [KW-1:0]       key_waddr;
    logic [47:0]         key_wdata;
    logic                in_valid;
    logic                in_ready;
    logic [32*LANES-1:0] in_data;
    logic                in_first;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [48*LANES-1:0] out_data;
    logic [KW-1:0]       out_round;
    logic                out_last;

    int vectors;
    int miscompares;

    exp_mix_pipe #(.LANES(LANES), .KEY_DEPTH(KD)) dut (
        .clk(clk), .reset(reset),
        .key_we(key_we), .key_waddr(key_waddr), .key_wdata(key_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_round(out_round), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Classic DES E table, 1-based source bit numbers with bit 1 = MSB.
    int etab [48] = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,
                       8, 9,10,11,12,13, 12,13,14,15,16,17,
                      16,17,18,19,20,21, 20,21,22,23,24,25,
                      24,25,26,27,28,29, 28,29,30,31,32, 1};

    // Reference model state
    logic [47:0]         m_key [KD];
    int                  m_cnt;
    logic                m_mode;
    logic                m_ov;
    logic [48*LANES-1:0] m_od;
    logic [KW-1:0]       m_round;
    logic                m_last;

    function automatic logic [47:0] ref_expand(input logic [31:0] d);
        logic [47:0] e;
        for (int j = 0; j < 48; j++) begin
            e[47-j] = d[32-etab[j]];
        end
        return e;
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic step();
        logic acc;
        logic msel;
        int   idx;
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_mode = 0; m_ov = 0; m_od = '0; m_round = '0; m_last = 0;
            for (int k = 0; k < KD; k++) m_key[k] = '0;
        end else begin
            acc = in_valid && (!m_ov || out_ready);
            if (acc) begin
                msel = in_first ? in_mode : m_mode;
                idx  = in_first ? (in_mode ? KD-1 : 0) : m_cnt;
                for (int l = 0; l < LANES; l++)
                    m_od[48*l +: 48] = ref_expand(in_data[32*l +: 32]) ^ m_key[idx];
                m_ov    = 1;
                m_round = KW'(idx);
                m_last  = msel ? (idx == 0) : (idx == KD-1);
                m_mode  = msel;
                m_cnt   = msel ? (idx + KD - 1) % KD : (idx + 1) % KD;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (key_we) m_key[key_waddr] = key_wdata;
        end
        #1;
    endtask

    task automatic idle_inputs();
        key_we = 0; key_waddr = '0; key_wdata = '0;
        in_valid = 0; in_data = '0; in_first = 0; in_mode = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; in_valid = 1; in_first = 1; in_data = {LANES{32'hdead_beef}};
        key_we = 1; key_wdata = 48'h1234_5678_9abc;
        step(); step();
        vectors++;
        if ({out_valid, out_round, out_last, out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b r=%0d l=%b d=%h required all zero",
                     out_valid, out_round, out_last, out_data);
        end
        reset = 0; idle_inputs(); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        // Key written during reset must not survive: a beat with key 0 gives pure expansion.
        in_valid = 1; in_first = 1; in_data = '0;
        step();
        vectors++;
        if (out_data !== '0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_key_discard: got v=%b d=%h required v=1 d=0", out_valid, out_data);
        end
        idle_inputs(); step();
    endtask

    task automatic test_expand();
        logic [31:0] r;
        r = $urandom;
        in_valid = 1; in_first = 1; in_mode = 0; in_data = {r, 32'h0000_0001};
        step();
        vectors++;
        if (out_data[47:0] !== 48'h8000_0000_0002 || out_round !== 4'd0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL expand_bit0: got d=%h r=%0d l=%b required d=800000000002 r=0 l=0",
                     out_data[47:0], out_round, out_last);
        end
        vectors++;
        if (out_data[95:48] !== ref_expand(r)) begin
            miscompares++;
            $display("FAIL expand_lane1: got %h required %h", out_data[95:48], ref_expand(r));
        end
        idle_inputs(); step();
    endtask

    task automatic load_keys();
        for (int k = 0; k < KD; k++) begin
            key_we = 1; key_waddr = KW'(k); key_wdata = 48'h1 << k;
            step();
        end
        key_we = 0;
    endtask

    task automatic test_ascending();
        logic [47:0] e;
        load_keys();
        for (int k = 0; k < KD; k++) begin
            in_valid = 1; in_first = (k == 0); in_mode = 0; in_data = '0;
            step();
            e = 48'h1 << k;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== {e, e} || out_round !== KW'(k)
                || out_last !== (k == KD-1)) begin
                miscompares++;
                $display("FAIL ascending[%0d]: got v=%b d=%h r=%0d l=%b required v=1 d=%h r=%0d l=%b",
                         k, out_valid, out_data, out_round, out_last, {e, e}, k, (k == KD-1));
            end
        end
        idle_inputs(); step();
    endtask

    task automatic test_descending();
        logic [47:0] e;
        int rnd;
        for (int k = 0; k <= KD; k++) begin
            in_valid = 1; in_first = (k == 0); in_mode = (k == 0); in_data = '0;
            step();
            rnd = (KD - 1 - k + KD) % KD;
            e   = 48'h1 << rnd;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== {e, e} || out_round !== KW'(rnd)
                || out_last !== (rnd == 0)) begin
                miscompares++;
                $display("FAIL descending[%0d]: got v=%b d=%h r=%0d l=%b required v=1 d=%h r=%0d l=%b",
                         k, out_valid, out_data, out_round, out_last, {e, e}, rnd, (rnd == 0));
            end
        end
        idle_inputs(); step();
    endtask

    task automatic test_stall();
        logic [48*LANES-1:0] held;
        logic [48*LANES-1:0] b_exp;
        logic [31:0]         b;
        in_valid = 1; in_first = 1; in_mode = 0; in_data = {$urandom, $urandom};
        step();
        held = out_data;
        b = $urandom;
        in_first = 0; in_data = {b, b}; out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_in_ready[%0d]: got %b required 0", c, in_ready);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== held || out_round !== 4'd0 || out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h r=%0d required v=1 d=%h r=0",
                         c, out_valid, out_data, out_round, held);
            end
        end
        out_ready = 1; #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b required 1", in_ready);
        end
        step();
        b_exp = {2{ref_expand(b) ^ (48'h1 << 1)}};
        vectors++;
        if (out_round !== 4'd1 || out_data !== b_exp) begin
            miscompares++;
            $display("FAIL stall_next_round: got r=%0d d=%h required r=1 d=%h", out_round, out_data, b_exp);
        end
        idle_inputs(); step();
    endtask

    task automatic test_key_collide();
        key_we = 1; key_waddr = '0; key_wdata = 48'hFFFF_FFFF_FFFF;
        in_valid = 1; in_first = 1; in_mode = 0; in_data = '0;
        step();
        vectors++;
        if (out_data[47:0] !== 48'h1) begin
            miscompares++;
            $display("FAIL key_old_value: got %h required 000000000001", out_data[47:0]);
        end
        key_we = 0;
        step();
        vectors++;
        if (out_data[47:0] !== 48'hFFFF_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL key_new_value: got %h required ffffffffffff", out_data[47:0]);
        end
        idle_inputs(); step();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        in_valid = 1; in_first = 1; in_mode = 0; in_data = {$urandom, $urandom};
        step();
        in_first = 0; out_ready = 0;
        step();
        reset = 1; in_valid = 1; key_we = 1; key_waddr = '0; key_wdata = $urandom;
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got v=%b d=%h required v=0 d=0", out_valid, out_data);
        end
        reset = 0; key_we = 0; out_ready = 1;
        d = $urandom;
        in_valid = 1; in_first = 0; in_data = {d, d};
        step();
        vectors++;
        if (out_round !== 4'd0 || out_data !== {2{ref_expand(d)}} || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_round0: got r=%0d l=%b d=%h required r=0 l=0 d=%h",
                     out_round, out_last, out_data, {2{ref_expand(d)}});
        end
        idle_inputs(); step();
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            key_we    = ($urandom_range(0, 3) == 0);
            key_waddr = KW'($urandom);
            key_wdata = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 5) == 0);
            in_mode   = $urandom;
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            exp_rdy = !m_ov || out_ready;
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL random_ready[%0d]: got %b required %b", i, in_ready, exp_rdy);
            end
            step();
            vectors++;
            if ({out_valid, out_round, out_last, out_data} !== {m_ov, m_round, m_last, m_od}) begin
                miscompares++;
                $display("FAIL random_out[%0d]: got v=%b r=%0d l=%b d=%h required v=%b r=%0d l=%b d=%h",
                         i, out_valid, out_round, out_last, out_data, m_ov, m_round, m_last, m_od);
            end
        end
        reset = 0; idle_inputs(); step();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_cnt = 0; m_mode = 0; m_ov = 0; m_od = '0; m_round = '0; m_last = 0;
        for (int k = 0; k < KD; k++) m_key[k] = '0;
        reset = 1;
        idle_inputs();
        #1;
        test_reset();
        test_expand();
        test_ascending();
        test_descending();
        test_stall();
        test_key_collide();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
